// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the MIPS-subset datapath.
// Sequences fetch / decode / execute / memory / writeback and drives every
// datapath enable and mux select from the registered state. The machine halts
// on break, on an undefined opcode/funct, or on arithmetic overflow, and it
// leaves HALT only through reset.
module multicycle_control_unit #(
  parameter logic [5:0] BRK_FUNCT = 6'h0D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Func,
  input  logic       Overflow,
  input  logic       EQ,
  output logic       PCWrite,
  output logic       PCLoad,
  output logic [2:0] SrcAddressMem,
  output logic       MemOp,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       WriteA,
  output logic       WriteB,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       WriteALUOut,
  output logic [1:0] PCSource,
  output logic [2:0] MemToReg,
  output logic [2:0] RegDst,
  output logic       halted,
  output logic       exception
);

  localparam logic [4:0] S_RESET    = 5'd0;
  localparam logic [4:0] S_FETCH    = 5'd1;
  localparam logic [4:0] S_IR_LOAD  = 5'd2;
  localparam logic [4:0] S_DECODE   = 5'd3;
  localparam logic [4:0] S_R_ADD    = 5'd4;
  localparam logic [4:0] S_R_SUB    = 5'd5;
  localparam logic [4:0] S_R_AND    = 5'd6;
  localparam logic [4:0] S_R_WB     = 5'd7;
  localparam logic [4:0] S_SLT      = 5'd8;
  localparam logic [4:0] S_JR       = 5'd9;
  localparam logic [4:0] S_ADDI_EX  = 5'd10;
  localparam logic [4:0] S_ADDI_WB  = 5'd11;
  localparam logic [4:0] S_MEM_ADDR = 5'd12;
  localparam logic [4:0] S_LW_RD    = 5'd13;
  localparam logic [4:0] S_LW_WB    = 5'd14;
  localparam logic [4:0] S_SW_WR    = 5'd15;
  localparam logic [4:0] S_BRANCH   = 5'd16;
  localparam logic [4:0] S_JUMP     = 5'd17;
  localparam logic [4:0] S_HALT     = 5'd18;

  logic [4:0] state;
  logic [4:0] nextState;
  logic       ovfFlag;
  logic       nextOvf;
  logic       excFlag;
  logic       nextExc;
  logic       branchTaken;

  // Next-state logic, overflow capture in execute and halt-cause tracking
  always_comb begin
    nextState = S_RESET;
    nextOvf   = ovfFlag;
    nextExc   = excFlag;
    case (state)
      S_RESET: begin
        nextState = S_FETCH;
        nextOvf   = 1'b0;
        nextExc   = 1'b0;
      end
      S_FETCH:   nextState = S_IR_LOAD;
      S_IR_LOAD: nextState = S_DECODE;
      S_DECODE: begin
        if (OpCode == 6'h00) begin
          if (Func == 6'h20) begin
            nextState = S_R_ADD;
          end else if (Func == 6'h22) begin
            nextState = S_R_SUB;
          end else if (Func == 6'h24) begin
            nextState = S_R_AND;
          end else if (Func == 6'h2A) begin
            nextState = S_SLT;
          end else if (Func == 6'h08) begin
            nextState = S_JR;
          end else if (Func == BRK_FUNCT) begin
            nextState = S_HALT;
            nextExc   = 1'b0;
          end else begin
            nextState = S_HALT;
            nextExc   = 1'b1;
          end
        end else begin
          case (OpCode)
            6'h08:        nextState = S_ADDI_EX;
            6'h23, 6'h2B: nextState = S_MEM_ADDR;
            6'h04, 6'h05: nextState = S_BRANCH;
            6'h02:        nextState = S_JUMP;
            default: begin
              nextState = S_HALT;
              nextExc   = 1'b1;
            end
          endcase
        end
      end
      S_R_ADD, S_R_SUB: begin
        nextState = S_R_WB;
        nextOvf   = Overflow;
      end
      S_R_AND: begin
        nextState = S_R_WB;
        nextOvf   = 1'b0;
      end
      S_ADDI_EX: begin
        nextState = S_ADDI_WB;
        nextOvf   = Overflow;
      end
      S_R_WB, S_ADDI_WB: begin
        if (ovfFlag) begin
          nextState = S_HALT;
          nextExc   = 1'b1;
        end else begin
          nextState = S_FETCH;
        end
      end
      S_SLT:      nextState = S_FETCH;
      S_JR:       nextState = S_FETCH;
      S_MEM_ADDR: nextState = (OpCode == 6'h23) ? S_LW_RD : S_SW_WR;
      S_LW_RD:    nextState = S_LW_WB;
      S_LW_WB:    nextState = S_FETCH;
      S_SW_WR:    nextState = S_FETCH;
      S_BRANCH:   nextState = S_FETCH;
      S_JUMP:     nextState = S_FETCH;
      S_HALT:     nextState = S_HALT;
      default:    nextState = S_RESET;
    endcase
  end

  // State, overflow flag and halt-cause registers; reset wins at any time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_RESET;
      ovfFlag <= 1'b0;
      excFlag <= 1'b0;
    end else begin
      state   <= nextState;
      ovfFlag <= nextOvf;
      excFlag <= nextExc;
    end
  end

  // Moore decode of every control output from the registered state
  always_comb begin
    PCWrite       = 1'b0;
    SrcAddressMem = 3'd0;
    MemOp         = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    WriteA        = 1'b0;
    WriteB        = 1'b0;
    ALUSrcA       = 2'd0;
    ALUSrcB       = 3'd0;
    ALUOp         = 3'b000;
    WriteALUOut   = 1'b0;
    PCSource      = 2'd0;
    MemToReg      = 3'd0;
    RegDst        = 3'd0;
    halted        = 1'b0;
    exception     = 1'b0;
    case (state)
      S_IR_LOAD: begin
        IRWrite = 1'b1;
        ALUSrcB = 3'd1;
        ALUOp   = 3'b001;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        WriteA      = 1'b1;
        WriteB      = 1'b1;
        ALUSrcB     = 3'd3;
        ALUOp       = 3'b001;
        WriteALUOut = 1'b1;
      end
      S_R_ADD, S_R_SUB, S_R_AND: begin
        ALUSrcA     = 2'd1;
        WriteALUOut = 1'b1;
        ALUOp       = (state == S_R_ADD) ? 3'b001 :
                      (state == S_R_SUB) ? 3'b010 : 3'b011;
      end
      S_R_WB: begin
        RegDst   = 3'd1;
        RegWrite = ~ovfFlag;
      end
      S_SLT: begin
        ALUSrcA  = 2'd1;
        ALUOp    = 3'b111;
        MemToReg = 3'd2;
        RegDst   = 3'd1;
        RegWrite = 1'b1;
      end
      S_JR: begin
        ALUSrcA = 2'd1;
        PCWrite = 1'b1;
      end
      S_ADDI_EX, S_MEM_ADDR: begin
        ALUSrcA     = 2'd1;
        ALUSrcB     = 3'd2;
        ALUOp       = 3'b001;
        WriteALUOut = 1'b1;
      end
      S_ADDI_WB: RegWrite = ~ovfFlag;
      S_LW_RD:   SrcAddressMem = 3'd1;
      S_LW_WB: begin
        MemToReg = 3'd1;
        RegWrite = 1'b1;
      end
      S_SW_WR: begin
        SrcAddressMem = 3'd1;
        MemOp         = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 2'd1;
        ALUOp    = 3'b111;
        PCSource = 2'd1;
      end
      S_JUMP: begin
        PCSource = 2'd2;
        PCWrite  = 1'b1;
      end
      S_HALT: begin
        halted    = 1'b1;
        exception = excFlag;
      end
      default: ;
    endcase
  end

  // Conditional PC enable: beq loads on EQ, bne loads on not-EQ
  always_comb begin
    branchTaken = (state == S_BRANCH) && ((OpCode == 6'h04) ? EQ : ~EQ);
    PCLoad      = PCWrite | branchTaken;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit. Each cycle the full control
// word is compared against a hand-written per-state table of expected values.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode;
  logic [5:0] Func;
  logic       Overflow;
  logic       EQ;
  logic       PCWrite;
  logic       PCLoad;
  logic [2:0] SrcAddressMem;
  logic       MemOp;
  logic       IRWrite;
  logic       RegWrite;
  logic       WriteA;
  logic       WriteB;
  logic [1:0] ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       WriteALUOut;
  logic [1:0] PCSource;
  logic [2:0] MemToReg;
  logic [2:0] RegDst;
  logic       halted;
  logic       exception;

  typedef struct packed {
    logic       pcWrite;
    logic       pcLoad;
    logic [2:0] srcAddressMem;
    logic       memOp;
    logic       irWrite;
    logic       regWrite;
    logic       writeA;
    logic       writeB;
    logic [1:0] aluSrcA;
    logic [2:0] aluSrcB;
    logic [2:0] aluOp;
    logic       writeALUOut;
    logic [1:0] pcSource;
    logic [2:0] memToReg;
    logic [2:0] regDst;
    logic       halted;
    logic       exception;
  } ctl_t;

  localparam int T_RESET   = 0;
  localparam int T_FETCH   = 1;
  localparam int T_IR      = 2;
  localparam int T_DEC     = 3;
  localparam int T_RADD    = 4;
  localparam int T_RSUB    = 5;
  localparam int T_RAND    = 6;
  localparam int T_RWB     = 7;
  localparam int T_RWB_OVF = 8;
  localparam int T_SLT     = 9;
  localparam int T_JR      = 10;
  localparam int T_ADDIEX  = 11;
  localparam int T_ADDIWB  = 12;
  localparam int T_MEMADDR = 13;
  localparam int T_LWRD    = 14;
  localparam int T_LWWB    = 15;
  localparam int T_SWWR    = 16;
  localparam int T_BR_T    = 17;
  localparam int T_BR_N    = 18;
  localparam int T_JUMP    = 19;
  localparam int T_HALT    = 20;
  localparam int T_HALT_X  = 21;

  int   totalCount = 0;
  int   badCount   = 0;
  ctl_t obs;

  multicycle_control_unit #(.BRK_FUNCT(6'h0D)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Func(Func),
    .Overflow(Overflow), .EQ(EQ), .PCWrite(PCWrite), .PCLoad(PCLoad),
    .SrcAddressMem(SrcAddressMem), .MemOp(MemOp), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .WriteA(WriteA), .WriteB(WriteB),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .WriteALUOut(WriteALUOut), .PCSource(PCSource), .MemToReg(MemToReg),
    .RegDst(RegDst), .halted(halted), .exception(exception)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Collect every DUT output into one comparable control word
  assign obs = {PCWrite, PCLoad, SrcAddressMem, MemOp, IRWrite, RegWrite,
                WriteA, WriteB, ALUSrcA, ALUSrcB, ALUOp, WriteALUOut,
                PCSource, MemToReg, RegDst, halted, exception};

  // Expected control word for each state, written out from the state table
  function automatic ctl_t expFor(input int st);
    ctl_t c;
    c = '0;
    case (st)
      T_IR: begin
        c.irWrite = 1'b1; c.aluSrcB = 3'd1; c.aluOp = 3'b001;
        c.pcWrite = 1'b1; c.pcLoad = 1'b1;
      end
      T_DEC: begin
        c.writeA = 1'b1; c.writeB = 1'b1; c.aluSrcB = 3'd3;
        c.aluOp = 3'b001; c.writeALUOut = 1'b1;
      end
      T_RADD: begin c.aluSrcA = 2'd1; c.aluOp = 3'b001; c.writeALUOut = 1'b1; end
      T_RSUB: begin c.aluSrcA = 2'd1; c.aluOp = 3'b010; c.writeALUOut = 1'b1; end
      T_RAND: begin c.aluSrcA = 2'd1; c.aluOp = 3'b011; c.writeALUOut = 1'b1; end
      T_RWB:     begin c.regDst = 3'd1; c.regWrite = 1'b1; end
      T_RWB_OVF: c.regDst = 3'd1;
      T_SLT: begin
        c.aluSrcA = 2'd1; c.aluOp = 3'b111; c.memToReg = 3'd2;
        c.regDst = 3'd1; c.regWrite = 1'b1;
      end
      T_JR: begin c.aluSrcA = 2'd1; c.pcWrite = 1'b1; c.pcLoad = 1'b1; end
      T_ADDIEX, T_MEMADDR: begin
        c.aluSrcA = 2'd1; c.aluSrcB = 3'd2; c.aluOp = 3'b001; c.writeALUOut = 1'b1;
      end
      T_ADDIWB: c.regWrite = 1'b1;
      T_LWRD:   c.srcAddressMem = 3'd1;
      T_LWWB:   begin c.memToReg = 3'd1; c.regWrite = 1'b1; end
      T_SWWR:   begin c.srcAddressMem = 3'd1; c.memOp = 1'b1; end
      T_BR_T: begin
        c.aluSrcA = 2'd1; c.aluOp = 3'b111; c.pcSource = 2'd1; c.pcLoad = 1'b1;
      end
      T_BR_N:   begin c.aluSrcA = 2'd1; c.aluOp = 3'b111; c.pcSource = 2'd1; end
      T_JUMP:   begin c.pcSource = 2'd2; c.pcWrite = 1'b1; c.pcLoad = 1'b1; end
      T_HALT:   c.halted = 1'b1;
      T_HALT_X: begin c.halted = 1'b1; c.exception = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  // Single comparison point: counts and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    totalCount++;
    if (got !== want) begin
      badCount++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Present an instruction's opcode/funct fields
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn);
    OpCode = op;
    Func   = fn;
  endtask

  // Advance one clock and compare the control word with a state's table entry
  task automatic stepCheck(input string tag, input int st);
    @(posedge clk);
    #1;
    checkOutput(tag, {2'b00, obs}, {2'b00, expFor(st)});
  endtask

  // Assert reset between edges, confirm outputs drop at once, then release
  task automatic doReset(input string tag);
    reset = 1'b1;
    #2;
    checkOutput({tag, ".async"}, {2'b00, obs}, {2'b00, expFor(T_RESET)});
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput({tag, ".held"}, {2'b00, obs}, {2'b00, expFor(T_RESET)});
  endtask

  // Directed instruction sequence
  initial begin
    reset    = 1'b1;
    OpCode   = 6'h00;
    Func     = 6'h00;
    Overflow = 1'b0;
    EQ       = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstIdle", {2'b00, obs}, {2'b00, expFor(T_RESET)});
    reset = 1'b0;

    applyStimulus(6'h08, 6'h05);
    stepCheck("addi.fetch", T_FETCH);
    stepCheck("addi.ir", T_IR);
    stepCheck("addi.dec", T_DEC);
    stepCheck("addi.ex", T_ADDIEX);
    stepCheck("addi.wb", T_ADDIWB);

    applyStimulus(6'h23, 6'h00);
    stepCheck("lw.fetch", T_FETCH);
    stepCheck("lw.ir", T_IR);
    stepCheck("lw.dec", T_DEC);
    stepCheck("lw.addr", T_MEMADDR);
    stepCheck("lw.rd", T_LWRD);
    stepCheck("lw.wb", T_LWWB);

    applyStimulus(6'h2B, 6'h00);
    stepCheck("sw.fetch", T_FETCH);
    stepCheck("sw.ir", T_IR);
    stepCheck("sw.dec", T_DEC);
    stepCheck("sw.addr", T_MEMADDR);
    stepCheck("sw.wr", T_SWWR);

    applyStimulus(6'h04, 6'h00);
    EQ = 1'b1;
    stepCheck("beqT.fetch", T_FETCH);
    stepCheck("beqT.ir", T_IR);
    stepCheck("beqT.dec", T_DEC);
    stepCheck("beqT.br", T_BR_T);
    EQ = 1'b0;
    stepCheck("beqN.fetch", T_FETCH);
    stepCheck("beqN.ir", T_IR);
    stepCheck("beqN.dec", T_DEC);
    stepCheck("beqN.br", T_BR_N);

    applyStimulus(6'h05, 6'h00);
    EQ = 1'b1;
    stepCheck("bneN.fetch", T_FETCH);
    stepCheck("bneN.ir", T_IR);
    stepCheck("bneN.dec", T_DEC);
    stepCheck("bneN.br", T_BR_N);
    EQ = 1'b0;
    stepCheck("bneT.fetch", T_FETCH);
    stepCheck("bneT.ir", T_IR);
    stepCheck("bneT.dec", T_DEC);
    stepCheck("bneT.br", T_BR_T);

    applyStimulus(6'h02, 6'h00);
    stepCheck("j.fetch", T_FETCH);
    stepCheck("j.ir", T_IR);
    stepCheck("j.dec", T_DEC);
    stepCheck("j.jump", T_JUMP);

    applyStimulus(6'h00, 6'h08);
    stepCheck("jr.fetch", T_FETCH);
    stepCheck("jr.ir", T_IR);
    stepCheck("jr.dec", T_DEC);
    stepCheck("jr.jr", T_JR);

    applyStimulus(6'h00, 6'h2A);
    stepCheck("slt.fetch", T_FETCH);
    stepCheck("slt.ir", T_IR);
    stepCheck("slt.dec", T_DEC);
    stepCheck("slt.slt", T_SLT);

    applyStimulus(6'h00, 6'h22);
    stepCheck("sub.fetch", T_FETCH);
    stepCheck("sub.ir", T_IR);
    stepCheck("sub.dec", T_DEC);
    stepCheck("sub.ex", T_RSUB);
    stepCheck("sub.wb", T_RWB);

    // and ignores the ALU overflow flag
    applyStimulus(6'h00, 6'h24);
    stepCheck("and.fetch", T_FETCH);
    stepCheck("and.ir", T_IR);
    stepCheck("and.dec", T_DEC);
    stepCheck("and.ex", T_RAND);
    Overflow = 1'b1;
    stepCheck("and.wb", T_RWB);
    Overflow = 1'b0;

    // add with overflow suppresses the write and halts with exception
    applyStimulus(6'h00, 6'h20);
    stepCheck("addOvf.fetch", T_FETCH);
    stepCheck("addOvf.ir", T_IR);
    stepCheck("addOvf.dec", T_DEC);
    stepCheck("addOvf.ex", T_RADD);
    Overflow = 1'b1;
    stepCheck("addOvf.wb", T_RWB_OVF);
    Overflow = 1'b0;
    for (int i = 0; i < 10; i++) stepCheck("addOvf.halt", T_HALT_X);

    // addi with overflow behaves the same way
    doReset("rst1");
    applyStimulus(6'h08, 6'h00);
    stepCheck("addiOvf.fetch", T_FETCH);
    stepCheck("addiOvf.ir", T_IR);
    stepCheck("addiOvf.dec", T_DEC);
    stepCheck("addiOvf.ex", T_ADDIEX);
    Overflow = 1'b1;
    stepCheck("addiOvf.wb", T_RESET);
    Overflow = 1'b0;
    stepCheck("addiOvf.halt", T_HALT_X);

    doReset("rst2");
    applyStimulus(6'h3F, 6'h00);
    stepCheck("undefOp.fetch", T_FETCH);
    stepCheck("undefOp.ir", T_IR);
    stepCheck("undefOp.dec", T_DEC);
    stepCheck("undefOp.halt", T_HALT_X);
    stepCheck("undefOp.stay", T_HALT_X);

    doReset("rst3");
    applyStimulus(6'h00, 6'h0D);
    stepCheck("brk.fetch", T_FETCH);
    stepCheck("brk.ir", T_IR);
    stepCheck("brk.dec", T_DEC);
    stepCheck("brk.halt", T_HALT);
    stepCheck("brk.stay", T_HALT);

    doReset("rst4");
    applyStimulus(6'h00, 6'h3F);
    stepCheck("undefFn.fetch", T_FETCH);
    stepCheck("undefFn.ir", T_IR);
    stepCheck("undefFn.dec", T_DEC);
    stepCheck("undefFn.halt", T_HALT_X);

    // Reset taken in the middle of a load, then a clean restart
    doReset("rst5");
    applyStimulus(6'h23, 6'h00);
    stepCheck("lwAbort.fetch", T_FETCH);
    stepCheck("lwAbort.ir", T_IR);
    stepCheck("lwAbort.dec", T_DEC);
    stepCheck("lwAbort.addr", T_MEMADDR);
    stepCheck("lwAbort.rd", T_LWRD);
    doReset("rstMid");
    applyStimulus(6'h08, 6'h00);
    stepCheck("restart.fetch", T_FETCH);
    stepCheck("restart.ir", T_IR);
    stepCheck("restart.dec", T_DEC);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
